// File: rtl/regfile_dump.sv
// Debug readout engine: scans the register file over its spare read port and streams each word out on valid/ready.
// Optional trailing XOR checksum word when REGDUMP_CHECKSUM_EN is defined.
module regfile_dump #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W:0]   out_idx
);

    typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ADDR_W:0]     oidx_q, oidx_d;
    logic                vld_q, vld_d;
`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0]   csum_q, csum_d;
    logic                chk_q, chk_d;   // checksum word is the one currently presented
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            oidx_q  <= '0;
            vld_q   <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            csum_q  <= '0;
            chk_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            oidx_q  <= oidx_d;
            vld_q   <= vld_d;
`ifdef REGDUMP_CHECKSUM_EN
            csum_q  <= csum_d;
            chk_q   <= chk_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        oidx_d  = oidx_q;
        vld_d   = vld_q;
`ifdef REGDUMP_CHECKSUM_EN
        csum_d  = csum_q;
        chk_d   = chk_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    state_d = READ;
`ifdef REGDUMP_CHECKSUM_EN
                    csum_d  = '0;
                    chk_d   = 1'b0;
`endif
                end
            end
            READ: begin
                data_d  = rf_rdata;
                oidx_d  = {1'b0, idx_q};
                vld_d   = 1'b1;
                state_d = SEND;
`ifdef REGDUMP_CHECKSUM_EN
                csum_d  = csum_q ^ rf_rdata;
`endif
            end
            SEND: begin
                if (vld_q && out_ready) begin
                    vld_d = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
                    if (chk_q) begin
                        state_d = DONE;
                    end else if (idx_q == LAST_IDX) begin
                        // Checksum goes straight back into SEND; idx stays at the last register.
                        data_d  = csum_q;
                        oidx_d  = (ADDR_W+1)'(NUM_REGS);
                        vld_d   = 1'b1;
                        chk_d   = 1'b1;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = READ;
                    end
`else
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = READ;
                    end
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q == READ) || (state_q == SEND);
    assign done      = (state_q == DONE);
    assign rf_raddr  = idx_q;
    assign out_valid = vld_q;
    assign out_data  = data_q;
    assign out_idx   = oidx_q;

endmodule
